pipe_stage_reg_elastic: RTL
===========================

Name: pipe_stage_reg_elastic

Overview:
Parametrised elastic pipeline-stage register. It generalises the fixed-field ID→EXE stage register into a generic payload register with a valid/ready handshake and a 2-entry skid buffer. It supports synchronous flush (bubble insertion) and a back-pressure stall counter. It is instantiated between any two pipeline stages (IF→ID, ID→EXE, EXE→MEM); payload packing and unpacking is done by the caller.

Parameters:
DATA_W, 150, payload width in bits (the full ID→EXE bundle).
CTRL_W, 6, number of payload LSBs that are side-effecting enables (writeback, memRead, memWrite, branch, S, imm); these are forced to 0 whenever out_valid=0. Must satisfy 1 <= CTRL_W <= DATA_W.
CNT_W, 16, width of the stall counter.

Ports:
clk  input  1  clock, rising edge
rst  input  1  reset, asynchronous, active-high
flush  input  1  synchronous squash of all held entries
in_valid  input  1  upstream offers in_data
in_ready  output  1  stage can accept; a transfer happens when in_valid && in_ready
in_data  input  DATA_W  upstream payload
out_valid  output  1  out_data holds a live entry
out_ready  input  1  downstream accepts; a transfer happens when out_valid && out_ready
out_data  output  DATA_W  payload to downstream
stall_cycles  output  CNT_W  saturating count of cycles with out_valid && !out_ready

Behaviour:
- Storage: main register (main_v, main_d) and skid register (skid_v, skid_d). out_data is driven from main_d. Entries leave in arrival order.
- State is encoded by {skid_v, main_v}: EMPTY=00, FULL=01, SKID=11. The value 10 is illegal and must be unreachable.
- in_ready = !skid_v, a pure function of registered state. There is no combinational path from out_ready to in_ready.
- out_valid = main_v.
- out_data[CTRL_W-1:0] = main_d[CTRL_W-1:0] & {CTRL_W{main_v}}.
- out_data[DATA_W-1:CTRL_W] = main_d upper bits, unmasked; content is don't-care when invalid.
- Let inf = in_valid && in_ready and outf = out_valid && out_ready. Transitions when flush=0:
  - EMPTY: inf → FULL, main_d<=in_data. Otherwise stay in EMPTY.
  - FULL: inf&&outf → FULL, main_d<=in_data. outf only → EMPTY. inf only → SKID, skid_d<=in_data. Neither → hold.
  - SKID: outf → FULL, main_d<=skid_d, skid_v<=0. Otherwise hold. in_ready=0, so inf is impossible.
- Latency: an entry accepted in cycle N is out_valid in cycle N+1. Sustained throughput is 1 transfer/cycle when out_ready=1.
- Flush has highest priority over every transition. Next state is EMPTY: main_v=0, skid_v=0.
  - A transfer offered in the flush cycle is discarded. in_ready may read 1 in that cycle, but the data is not captured.
  - An outf in the flush cycle still counts as delivered downstream; that is the consumer's concern.
  - Data registers need not be cleared on flush; the masking covers the CTRL bits.
- Stall counter: increments by 1 in every cycle where out_valid && !out_ready, including the flush cycle. It saturates at 2^CNT_W−1 and does not wrap. It is cleared only by rst.
- Reset (asynchronous, any time including mid-transfer):
  - main_v=0, skid_v=0, main_d=0, skid_d=0, stall_cycles=0.
  - Outputs during and after reset: out_valid=0, out_data=0, in_ready=1.
  - The first capture is possible on the first clk edge after rst deasserts.
- Input data is captured only on inf; in_data is ignored otherwise. The payload is not interpreted beyond the CTRL masking.

Test Plan:
- Reset/idle: assert rst mid-stream with both entries held → out_valid=0, out_data=0, in_ready=1, stall_cycles=0 immediately, before any clock edge. After release and idle cycles, the state stays unchanged.
- Latency/streaming: out_ready=1, push 0x...01, 0x...02, 0x...03 on consecutive cycles.
  - Each appears on out_data exactly 1 cycle after acceptance, in order.
  - in_ready stays 1 throughout.
- Back-pressure/skid: out_ready=0, push A then B.
  - After B: in_ready=0 and C is held off.
  - Raise out_ready → A, then B, then C delivered in order, with no loss or duplication.
  - stall_cycles equals the number of cycles out_valid was 1 while out_ready was 0.
- Flush: in SKID state, pulse flush together with in_valid carrying D.
  - Next cycle: out_valid=0, out_data[5:0]=0, in_ready=1.
  - D is never delivered.
  - The following push E appears 1 cycle later.
- Bubble masking: set payload with low 6 bits = 6'b111111, accept it, then let it drain.
  - While out_valid=0, out_data[5:0]=0.
  - Upper bits are unconstrained.
- Saturation: CNT_W=3, hold out_valid=1 and out_ready=0 for 10 cycles → stall_cycles reads 1..7 and then stays at 7, with no wrap.

Source files
------------

// File: rtl/pipe_stage_reg_elastic.sv
//------------------------------------------------------------------------------
// pipe_stage_reg_elastic
//
// Generic elastic pipeline-stage register with a valid/ready handshake on both
// sides and a 2-entry (main + skid) buffer. It sits between two pipeline
// stages; the caller packs and unpacks the payload. The stage can hold one
// extra entry, so in_ready depends only on registered state and never on
// out_ready. Sustained throughput is therefore one transfer per cycle.
//
// Parameters
//   DATA_W  payload width in bits
//   CTRL_W  number of payload LSBs that carry side-effecting enables. These
//           bits read as zero whenever out_valid is low. Range 1..DATA_W.
//   CNT_W   width of the saturating back-pressure stall counter
//
// Ports
//   clk           clock, rising edge
//   rst           asynchronous active-high reset
//   flush         synchronous squash of every held entry (bubble insertion)
//   in_valid      upstream offers in_data
//   in_ready      stage can accept (low only while the skid entry is occupied)
//   in_data       upstream payload
//   out_valid     out_data holds a live entry
//   out_ready     downstream accepts
//   out_data      payload to downstream, control LSBs masked when invalid
//   stall_cycles  saturating count of cycles with out_valid && !out_ready
//------------------------------------------------------------------------------
module pipe_stage_reg_elastic #(
   parameter int DATA_W = 150,
   parameter int CTRL_W = 6,
   parameter int CNT_W  = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              flush,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data,
   output logic [CNT_W-1:0]  stall_cycles
);

   // State encoding is {skidValid, mainValid}. The value 2'b10 would mean
   // "skid occupied but main empty", which would break arrival ordering.
   // The transitions never produce it, and the default arm recovers from it.
   typedef enum logic [1:0] {
      EMPTY = 2'b00,
      FULL  = 2'b01,
      SKID  = 2'b11
   } state_t;

   // Mask that keeps the payload bits above the control field. It is all
   // zeros when CTRL_W == DATA_W, because the shift then yields zero.
   localparam logic [DATA_W-1:0] UPPER_KEEP =
      ~((DATA_W'(1'b1) << CTRL_W) - DATA_W'(1'b1));

   localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

   state_t            state_r;
   logic [DATA_W-1:0] mainData_r;
   logic [DATA_W-1:0] skidData_r;
   logic [CNT_W-1:0]  stallCnt_r;

   logic [1:0]        stateBits_s;
   logic              mainValid_s;
   logic              skidValid_s;
   logic              inFire_s;
   logic              outFire_s;
   logic              stallNow_s;

   // Zero the control field of a payload word. This keeps the invariant that
   // a non-live main entry never holds asserted enables.
   function automatic logic [DATA_W-1:0] clearCtrl(input logic [DATA_W-1:0] d);
      clearCtrl = d & UPPER_KEEP;
   endfunction

   // Apply the control-field mask according to the liveness of the entry.
   function automatic logic [DATA_W-1:0] maskCtrl(input logic [DATA_W-1:0] d,
                                                  input logic              live);
      maskCtrl = d & (UPPER_KEEP | {DATA_W{live}});
   endfunction

   assign stateBits_s = state_r;
   assign mainValid_s = stateBits_s[0];
   assign skidValid_s = stateBits_s[1];

   // Handshake qualifiers; inFire_s uses the registered in_ready term.
   assign inFire_s   = in_valid & ~skidValid_s;
   assign outFire_s  = mainValid_s & out_ready;
   assign stallNow_s = mainValid_s & ~out_ready;

   // Handshake state machine and payload storage. Flush overrides every
   // transition. A transfer offered in the flush cycle is dropped.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r    <= EMPTY;
         mainData_r <= {DATA_W{1'b0}};
         skidData_r <= {DATA_W{1'b0}};
      end else if (flush) begin
         state_r    <= EMPTY;
         mainData_r <= clearCtrl(mainData_r);
      end else begin
         case (state_r)
            EMPTY: begin
               if (inFire_s) begin
                  state_r    <= FULL;
                  mainData_r <= in_data;
               end else begin
                  state_r    <= EMPTY;
               end
            end
            FULL: begin
               if (inFire_s && outFire_s) begin
                  // Pass-through: the old entry leaves and the new one replaces it.
                  state_r    <= FULL;
                  mainData_r <= in_data;
               end else if (outFire_s) begin
                  state_r    <= EMPTY;
                  mainData_r <= clearCtrl(mainData_r);
               end else if (inFire_s) begin
                  // Downstream stalled: park the newcomer behind the main entry.
                  state_r    <= SKID;
                  skidData_r <= in_data;
               end else begin
                  state_r    <= FULL;
               end
            end
            SKID: begin
               // in_ready is low here, so only the drain side can move.
               if (outFire_s) begin
                  state_r    <= FULL;
                  mainData_r <= skidData_r;
               end else begin
                  state_r    <= SKID;
               end
            end
            default: begin
               state_r    <= EMPTY;
               mainData_r <= clearCtrl(mainData_r);
            end
         endcase
      end
   end

   // Saturating back-pressure counter. Flush does not clear it, and a stall
   // in the flush cycle still counts.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         stallCnt_r <= {CNT_W{1'b0}};
      end else if (stallNow_s && (stallCnt_r != CNT_MAX)) begin
         stallCnt_r <= stallCnt_r + CNT_W'(1'b1);
      end else begin
         stallCnt_r <= stallCnt_r;
      end
   end

   // Every output is taken directly from a register. The control mask is
   // applied again at the output as a second guard on the enable bits.
   assign in_ready     = ~skidValid_s;
   assign out_valid    = mainValid_s;
   assign out_data     = maskCtrl(mainData_r, mainValid_s);
   assign stall_cycles = stallCnt_r;

endmodule
